// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-addressed memory responder.
// Covers the FSM state type, the word size and the alignment/range check.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } memState_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_OFS_W = $clog2(WORD_BYTES);

  // True when the byte address is word aligned and its word index lies inside the array.
  function automatic logic addrOk(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = addr >> BYTE_OFS_W;
    return (addr[BYTE_OFS_W-1:0] == '0) && (word_idx < depth);
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous RAM. Read data is registered on the same enabled edge
// (read-before-write), and the storage array is deliberately never reset.
module word_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WIDTH       = 32,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one outstanding request, programmable wait states, then a held response.
// The storage access happens on the edge that enters RESP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRData,
  output logic        respErr
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  memState_t   state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        rdOk_q, rdOk_d;

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        acc_ok;
  logic        enter_resp;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_rdata;

  // With zero wait states RESP is entered straight from IDLE, before the
  // request has been captured, so the access uses the live request fields.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_write = reqWrite;
      cur_addr  = reqAddr;
      cur_wdata = reqWData;
    end
  end

  assign acc_ok = addrOk(cur_addr, DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdOk_d     = rdOk_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          write_d = reqWrite;
          addr_d  = reqAddr;
          wdata_d = reqWData;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d   = WAIT;
            waitCnt_d = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      RESP: begin
        if (respReady) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rdOk_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d  = ~acc_ok;
      rdOk_d = acc_ok & ~cur_write;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdOk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdOk_q    <= rdOk_d;
    end
  end

  assign ram_en = enter_resp & acc_ok;
  assign ram_we = ram_en & cur_write;

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WIDTH      (32)
  ) u_word_ram (
    .clk  (clock),
    .en   (ram_en),
    .we   (ram_we),
    .addr (cur_addr[BYTE_OFS_W +: AW]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

  // The RAM output register stays put through RESP because its enable only fires on entry.
  assign reqReady  = (state_q == IDLE);
  assign respValid = (state_q == RESP);
  assign respErr   = err_q;
  assign respRData = rdOk_q ? ram_rdata : '0;

endmodule
